// File: rtl/buffer_arbiter_if.sv
// Handshake bundle between the producers/consumer and buffer_arbiter.
// The arbiter takes the slave view; the surrounding logic drives the master view.
interface buffer_arbiter_if #(
    parameter int bitwidth    = 8,
    parameter int requesters  = 4,
    parameter int index_width = 2
);
    logic [requesters-1:0]          request;
    logic [requesters*bitwidth-1:0] value_in;
    logic [requesters-1:0]          grant;
    logic [bitwidth-1:0]            value_out;
    logic                           valid;
    logic                           ready;
    logic [index_width-1:0]         owner;

    modport master (
        output request,
        output value_in,
        output ready,
        input  grant,
        input  value_out,
        input  valid,
        input  owner
    );

    modport slave (
        input  request,
        input  value_in,
        input  ready,
        output grant,
        output value_out,
        output valid,
        output owner
    );
endinterface

// File: rtl/buffer_arbiter.sv
// Round-robin arbiter feeding one shared holding register that drains to a
// single consumer over valid/ready. All outputs come straight from flops.
module buffer_arbiter #(
    parameter int bitwidth    = 8,
    parameter int requesters  = 4,
    parameter int index_width = 2
) (
    input  logic             clock,
    input  logic             reset,
    buffer_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                  state_q;
    logic [bitwidth-1:0]     value_out_q;
    logic                    valid_q;
    logic [requesters-1:0]   grant_q;
    logic [index_width-1:0]  owner_q;
    logic [index_width-1:0]  last_q;

    logic [requesters-1:0]   eff_req_s;
    logic                    found_s;
    logic [index_width-1:0]  winner_s;
    logic [bitwidth-1:0]     winner_data_s;
    logic [requesters-1:0]   winner_onehot_s;

    // Index base+offset wrapped modulo the number of requesters.
    function automatic logic [index_width-1:0] rr_index(
        input logic [index_width-1:0] base,
        input int                     offset
    );
        int sum;
        sum = int'(base) + offset;
        if (sum >= requesters) begin
            sum = sum - requesters;
        end else begin
            sum = sum;
        end
        return index_width'(sum);
    endfunction

    function automatic logic [requesters-1:0] to_onehot(
        input logic [index_width-1:0] idx
    );
        logic [requesters-1:0] one;
        one = {{(requesters-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    // A producer still showing last cycle's grant is not eligible again.
    assign eff_req_s = bus.request & ~grant_q;

    // Search for the first eligible requester starting just after the last winner.
    always_comb begin
        logic [index_width-1:0] cand;
        cand          = '0;
        found_s       = 1'b0;
        winner_s      = '0;
        winner_data_s = '0;
        for (int k = 1; k <= requesters; k++) begin
            cand = rr_index(last_q, k);
            if (!found_s && eff_req_s[cand]) begin
                found_s       = 1'b1;
                winner_s      = cand;
                winner_data_s = bus.value_in[cand*bitwidth +: bitwidth];
            end else begin
                found_s = found_s;
            end
        end
        winner_onehot_s = to_onehot(winner_s);
    end

    // Arbitration FSM: capture, hold, and drain the shared register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            value_out_q <= '0;
            valid_q     <= 1'b0;
            grant_q     <= '0;
            owner_q     <= '0;
            last_q      <= index_width'(requesters - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_s) begin
                        value_out_q <= winner_data_s;
                        valid_q     <= 1'b1;
                        owner_q     <= winner_s;
                        last_q      <= winner_s;
                        grant_q     <= winner_onehot_s;
                        state_q     <= HOLD;
                    end else begin
                        grant_q <= '0;
                    end
                end
                HOLD: begin
                    // Accepting and refilling on the same edge keeps one word per cycle.
                    if (bus.ready && found_s) begin
                        value_out_q <= winner_data_s;
                        valid_q     <= 1'b1;
                        owner_q     <= winner_s;
                        last_q      <= winner_s;
                        grant_q     <= winner_onehot_s;
                        state_q     <= HOLD;
                    end else if (bus.ready) begin
                        valid_q <= 1'b0;
                        grant_q <= '0;
                        state_q <= IDLE;
                    end else begin
                        grant_q <= '0;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    grant_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.value_out = value_out_q;
    assign bus.valid     = valid_q;
    assign bus.grant     = grant_q;
    assign bus.owner     = owner_q;

endmodule

// File: doc/buffer_arbiter.md
Name: buffer_arbiter

Overview:
Shares one bitwidth-wide holding register among `requesters` producers using round-robin arbitration. The winner's value is captured into the shared register and presented to a single consumer with a valid/ready handshake. It sits in front of a consumer that can accept only one source at a time. It replaces ad-hoc muxing of several load-enabled buffers.

Parameters:
bitwidth, 8, width of each data word and of value_out
requesters, 4, number of producer ports (2..16)
index_width, 2, width of owner; must equal ceil(log2(requesters)), with a minimum of 1

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
request  input  requesters  bit i high = producer i has data on its slice of value_in
value_in  input  requesters*bitwidth  producer i data occupies bits [i*bitwidth +: bitwidth]
grant  output  requesters  registered one-hot pulse; one cycle, in the cycle after capture
value_out  output  bitwidth  captured word from the winning producer
valid  output  1  value_out holds an unconsumed word
ready  input  1  consumer accepts value_out when valid && ready at a rising edge
owner  output  index_width  index of the producer whose word is in value_out

Behaviour:
- All outputs are registered; nothing is combinational from inputs.
- Reset (synchronous, any state, including mid-handshake):
  - value_out=0, valid=0, grant=0, owner=0, state=IDLE.
  - last pointer = requesters-1, so producer 0 has first priority.
  - Any held word is discarded.
- States: IDLE (register empty) and HOLD (valid=1).
- Effective request = request & ~grant. The producer currently pulsing grant is masked out, so a producer that drops request one cycle late is not re-served.
- Winner: the first set bit of the effective request, searching from last+1 upward and wrapping modulo requesters.
- IDLE, effective request nonzero, at the edge:
  - value_out <= winner's slice; valid <= 1; owner <= winner; last <= winner.
  - grant <= one-hot(winner); state -> HOLD.
- IDLE, effective request zero: grant <= 0; all else unchanged.
- HOLD, ready=0: value_out, owner and valid are held; grant <= 0.
  - New requests wait and do not overwrite.
- HOLD, ready=1, effective request nonzero: word consumed and next winner captured in the same edge (back-to-back). valid stays 1, with the same updates as the IDLE capture.
- HOLD, ready=1, effective request zero: valid <= 0; grant <= 0; state -> IDLE.
  - value_out and owner keep their last values.
- ready is ignored in IDLE.
- Latency: request high at edge N gives value_out, valid and grant at edge N+1.
  - Throughput: one word per cycle when ready is held high.
- Producer contract:
  - value_in must be stable while request is high.
  - Drop request in the cycle grant is seen, unless another word is pending.
- Fairness: each continuously requesting producer is served within `requesters` captures.
- Simultaneous requests: exactly one grant bit per capture, never more.

Test Plan:
1. Reset, then request=0001 with slice0=0xA5 → one edge later: value_out=0xA5, valid=1, owner=0, grant=0001 for exactly one cycle. Then ready=1 for one edge → valid=0.
2. request=1111 held, all slices distinct (0x10,0x21,0x32,0x43), ready=1 held → owners 0,1,2,3,0 on consecutive cycles. valid stays 1 and value_out tracks each slice.
3. HOLD with owner=2, ready=0 for 5 cycles while request=1011 → value_out and owner unchanged, grant=0. On ready=1 → owner=3 (round-robin past 2).
4. Producer 1 keeps request high one cycle after its grant, ready=1, no other requests → not recaptured (masking). valid drops to 0 after consumption.
5. reset asserted in HOLD with valid=1 → next edge: valid=0, value_out=0, owner=0, grant=0. Then request=1100 → owner=2.
6. requesters=2, bitwidth=16: alternate single requests 01/10 with ready toggling → value_out is never overwritten while valid && !ready (scoreboard check on every accepted word).
